// File: rtl/axi4_lite_csr_master_pkg.sv
// Shared types and constants for the AXI4-Lite CSR master.
package axi4_lite_csr_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi4_lite_if.sv
// Minimal AXI4-Lite bus bundle (no prot/cache sidebands).
interface axi4_lite_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one response beat out.
// Define AXI4_LITE_CSR_MASTER_TIMEOUT_EN to add a watchdog that answers SLVERR on a stuck slave.
module axi4_lite_csr_master
  import axi4_lite_csr_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [3:0]        cmd_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_resp_o,
  output logic              rsp_timeout_o,
  axi4_lite_if.master       csr_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            r_state;
  logic              r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic              r_rsp_valid, r_rsp_timeout;
  logic [31:0]       r_rsp_rdata;
  logic [1:0]        r_rsp_resp;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_done, w_w_done;

  assign w_aw_hs   = r_awvalid & csr_o.awready;
  assign w_w_hs    = r_wvalid  & csr_o.wready;
  assign w_b_hs    = r_bready  & csr_o.bvalid;
  assign w_ar_hs   = r_arvalid & csr_o.arready;
  assign w_r_hs    = r_rready  & csr_o.rvalid;
  // A channel is done if it already handshook earlier or is handshaking now.
  assign w_aw_done = ~r_awvalid | csr_o.awready;
  assign w_w_done  = ~r_wvalid  | csr_o.wready;

`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_wdog;
  logic             w_busy, w_any_hs, w_expire;

  assign w_busy   = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                    (r_state == RD_REQ) || (r_state == RD_RESP);
  assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign w_expire = w_busy & ~w_any_hs & (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                r_wdog <= '0;
    else if (!w_busy || w_any_hs) r_wdog <= '0;
    else                         r_wdog <= r_wdog + 1'b1;
  end
`endif

  // NOTE: all state updates use non-blocking assignments so every branch
  // sees the pre-edge values, matching what the flops really do.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_bready      <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_timeout <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid_i) begin
          r_addr  <= cmd_addr_i;
          r_wdata <= cmd_wdata_i;
          r_wstrb <= cmd_wstrb_i;
          if (cmd_wr_i) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= WR_REQ;
          end else begin
            r_arvalid <= 1'b1;
            r_state   <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: if (w_b_hs) begin
          r_rsp_resp    <= csr_o.bresp;
          r_rsp_rdata   <= '0;
          r_rsp_timeout <= 1'b0;
          r_bready      <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_state       <= RESP;
        end
        RD_REQ: if (w_ar_hs) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= RD_RESP;
        end
        RD_RESP: if (w_r_hs) begin
          r_rsp_rdata   <= csr_o.rdata;
          r_rsp_resp    <= csr_o.rresp;
          r_rsp_timeout <= 1'b0;
          r_rready      <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_state       <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
      // Watchdog overrides whatever the case above scheduled this edge.
      if (w_expire) begin
        r_awvalid     <= 1'b0;
        r_wvalid      <= 1'b0;
        r_arvalid     <= 1'b0;
        r_bready      <= 1'b0;
        r_rready      <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_resp    <= RESP_SLVERR;
        r_rsp_rdata   <= '0;
        r_rsp_timeout <= 1'b1;
        r_state       <= RESP;
      end
`endif
    end
  end

  assign cmd_ready_o   = (r_state == IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_resp_o    = r_rsp_resp;
  assign rsp_timeout_o = r_rsp_timeout;

  assign csr_o.awaddr  = r_addr;
  assign csr_o.awvalid = r_awvalid;
  assign csr_o.wdata   = r_wdata;
  assign csr_o.wstrb   = r_wstrb;
  assign csr_o.wvalid  = r_wvalid;
  assign csr_o.bready  = r_bready;
  assign csr_o.araddr  = r_addr;
  assign csr_o.arvalid = r_arvalid;
  assign csr_o.rready  = r_rready;

endmodule

// File: tb/tb_axi4_lite_csr_master.sv
// Scoreboard bench for axi4_lite_csr_master against a small 4-register CSR slave model.
// Define AXI4_LITE_CSR_MASTER_TIMEOUT_EN on both bench and RTL to exercise the watchdog.
module tb_axi4_lite_csr_master;
  import axi4_lite_csr_master_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TO     = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;
  logic s_mute = 1'b0, s_late_b = 1'b0;

  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   rsp_rise_cyc = 0;
  logic prev_rv = 1'b0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_lite_if #(.ADDR_W(ADDR_W)) u_bus ();

  axi4_lite_csr_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_wr_i     (cmd_wr),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_wstrb_i  (cmd_wstrb),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_resp_o   (rsp_resp),
    .rsp_timeout_o(rsp_timeout),
    .csr_o        (u_bus)
  );

  assign u_bus.awready = s_awready;
  assign u_bus.wready  = s_wready;
  assign u_bus.arready = s_arready;

  // Slave: 4 words at 0x0..0xC, anything else answers SLVERR with zero data.
  logic [31:0] regs [4];
  logic        aw_got, w_got;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;

  always @(posedge clk or negedge rst_n) begin
    logic        got_a, got_w;
    logic [31:0] a, d, ra;
    logic [3:0]  s;
    if (!rst_n) begin
      u_bus.bvalid <= 1'b0;
      u_bus.rvalid <= 1'b0;
      u_bus.bresp  <= 2'b00;
      u_bus.rresp  <= 2'b00;
      u_bus.rdata  <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (u_bus.bvalid && u_bus.bready) u_bus.bvalid <= 1'b0;
      if (u_bus.rvalid && u_bus.rready) u_bus.rvalid <= 1'b0;
      got_a = aw_got | (u_bus.awvalid & s_awready);
      got_w = w_got  | (u_bus.wvalid  & s_wready);
      a = (u_bus.awvalid & s_awready) ? 32'(u_bus.awaddr) : aw_addr;
      d = (u_bus.wvalid  & s_wready)  ? u_bus.wdata : w_data;
      s = (u_bus.wvalid  & s_wready)  ? u_bus.wstrb : w_strb;
      if (got_a && got_w) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (!s_mute) begin
          if (a < 32'h10)
            for (int b = 0; b < 4; b++)
              if (s[b]) regs[a[3:2]][8*b +: 8] <= d[8*b +: 8];
          u_bus.bresp  <= (a < 32'h10) ? 2'b00 : 2'b10;
          u_bus.bvalid <= 1'b1;
        end
      end else begin
        aw_got <= got_a;
        w_got  <= got_w;
        aw_addr <= a;
        w_data  <= d;
        w_strb  <= s;
      end
      if (u_bus.arvalid && s_arready && !s_mute) begin
        ra = 32'(u_bus.araddr);
        u_bus.rvalid <= 1'b1;
        u_bus.rdata  <= (ra < 32'h10) ? regs[ra[3:2]] : 32'h0;
        u_bus.rresp  <= (ra < 32'h10) ? 2'b00 : 2'b10;
      end
      if (s_mute) u_bus.bvalid <= s_late_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on each rsp handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (rsp_valid && !prev_rv) rsp_rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
          check("rsp_resp",    64'(rsp_resp),    64'(e.resp));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
    prev_rv = rsp_valid;
  end

  // Call only at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input rsp_t e, output int acc_cyc);
    int n = 0;
    acc_cyc = 0;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) check("cmd_accept_bound", 64'd0, 64'd1);
    else acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin @(posedge clk); #1; n++; end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench hung");
  end

  initial begin
    int acc;
    rsp_t ok0;
    ok0 = '{rdata: 32'h0, resp: RESP_OKAY, to: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_valids", 64'({u_bus.awvalid, u_bus.wvalid, u_bus.arvalid}), 64'd0);
    check("rst_readys", 64'({u_bus.bready, u_bus.rready}), 64'd0);
    check("rst_rsp_fields", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Enable write, read back
    issue(1'b1, 32'h0, 32'h1, 4'hF, ok0, acc);
    wait_idle();
    issue(1'b0, 32'h0, 32'h0, 4'h0, '{rdata: 32'h1, resp: RESP_OKAY, to: 1'b0}, acc);
    wait_idle();

    // Write/read 0x4 and read latency
    issue(1'b1, 32'h4, 32'h2, 4'hF, ok0, acc);
    wait_idle();
    issue(1'b0, 32'h4, 32'h0, 4'h0, '{rdata: 32'h2, resp: RESP_OKAY, to: 1'b0}, acc);
    wait_idle();
    check("rd_latency", 64'(rsp_rise_cyc - acc), 64'd3);

    // Byte strobes
    issue(1'b1, 32'h8, 32'hAABBCCDD, 4'h5, ok0, acc);
    wait_idle();
    issue(1'b0, 32'h8, 32'h0, 4'h0, '{rdata: 32'h00BB00DD, resp: RESP_OKAY, to: 1'b0}, acc);
    wait_idle();

    // SLVERR pass-through
    issue(1'b1, 32'h40, 32'h1234, 4'hF, '{rdata: 32'h0, resp: RESP_SLVERR, to: 1'b0}, acc);
    wait_idle();
    issue(1'b0, 32'h40, 32'h0, 4'h0, '{rdata: 32'h0, resp: RESP_SLVERR, to: 1'b0}, acc);
    wait_idle();

    // awready held low for 3 cycles, wready high
    s_awready = 1'b0;
    issue(1'b1, 32'hC, 32'h5A, 4'hF, ok0, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_awvalid", 64'(u_bus.awvalid), 64'd1);
      check("stall_awaddr",  64'(u_bus.awaddr),  64'hC);
      check("stall_wvalid",  64'(u_bus.wvalid),  (i == 0) ? 64'd1 : 64'd0);
      check("stall_bready",  64'(u_bus.bready),  64'd0);
      @(posedge clk); #1;
    end
    s_awready = 1'b1;
    @(negedge clk);
    check("stall_bready_pre", 64'(u_bus.bready), 64'd0);
    @(posedge clk); #1;
    check("stall_bready_post", 64'({u_bus.bready, u_bus.awvalid}), 64'b10);
    wait_idle();
    issue(1'b0, 32'hC, 32'h0, 4'h0, '{rdata: 32'h5A, resp: RESP_OKAY, to: 1'b0}, acc);
    wait_idle();

    // Response back-pressure with a second command queued
    rsp_ready = 1'b0;
    issue(1'b1, 32'h0, 32'h3, 4'hF, ok0, acc);
    exp_q.push_back('{rdata: 32'h3, resp: RESP_OKAY, to: 1'b0});
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0;
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_fields", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_cmd_ready_hs", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_cmd_ready_next", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_second_accepted", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a write
    s_awready = 1'b0;
    issue(1'b1, 32'h4, 32'h9, 4'hF, ok0, acc);
    @(negedge clk);
    check("mid_awvalid", 64'(u_bus.awvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valids", 64'({u_bus.awvalid, u_bus.wvalid, u_bus.arvalid}), 64'd0);
    check("mid_rst_readys", 64'({u_bus.bready, u_bus.rready, rsp_valid}), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    s_awready = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    issue(1'b0, 32'h0, 32'h0, 4'h0, ok0, acc);
    wait_idle();

`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
    // Silent slave: watchdog answers, late bvalid is ignored
    s_mute = 1'b1;
    issue(1'b1, 32'h0, 32'h7, 4'hF, '{rdata: 32'h0, resp: RESP_SLVERR, to: 1'b1}, acc);
    wait_idle();
    check("to_latency", 64'(rsp_rise_cyc - acc), 64'(TO + 2));
    s_late_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_b_ignored", 64'({u_bus.bready, rsp_valid}), 64'd0);
      @(posedge clk); #1;
    end
    s_late_b = 1'b0;
    @(posedge clk); #1;
    s_mute = 1'b0;
    @(posedge clk); #1;
    issue(1'b1, 32'h4, 32'h11, 4'hF, ok0, acc);
    wait_idle();
    issue(1'b0, 32'h4, 32'h0, 4'h0, '{rdata: 32'h11, resp: RESP_OKAY, to: 1'b0}, acc);
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
